// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin bounded-burst arbiter for the FIFO write port
module fifo_write_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         ack,
  input  logic                 fifo_full,
  output logic                 fifo_wr,
  output logic [WIDTH-1:0]     fifo_data,
  output logic                 busy,
  output logic [IDX_W-1:0]     owner
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [IDX_W-1:0] own_q;
  logic [IDX_W-1:0] last_q;
  logic [CNT_W-1:0] cnt_q;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             own_req;
  logic [IDX_W-1:0] sel;
  logic [CNT_W-1:0] cnt_next;

  // Round-robin search: first requester after last_q, wrapping N-1 -> 0.
  // Scanning distances from far to near lets the nearest hit overwrite.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        if (i == (int'(last_q) + k) % N && req[i]) begin
          pick_valid = 1'b1;
          pick_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Request line of the current burst owner.
  always_comb begin
    own_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (own_q == IDX_W'(i)) own_req = req[i];
    end
  end

  // Zero-latency grant: in IDLE the fresh pick is acked, in BURST only the owner.
  always_comb begin
    ack = '0;
    sel = (state == IDLE) ? pick_idx : own_q;
    if (!reset && !fifo_full) begin
      for (int i = 0; i < N; i++) begin
        if (state == IDLE) begin
          if (pick_valid && pick_idx == IDX_W'(i)) ack[i] = 1'b1;
        end else begin
          if (own_req && own_q == IDX_W'(i)) ack[i] = 1'b1;
        end
      end
    end
  end

  // Write strobe and data mux; data is forced to zero when nothing is written.
  always_comb begin
    fifo_wr   = |ack;
    fifo_data = '0;
    for (int i = 0; i < N; i++) begin
      if (fifo_wr && sel == IDX_W'(i)) fifo_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Status outputs are masked during reset so the first reset cycle is clean.
  always_comb begin
    busy  = !reset && (state == BURST);
    owner = reset ? '0 : own_q;
  end

  assign cnt_next = cnt_q + CNT_W'(1);

  // Ownership FSM: arbitrate in IDLE, count beats in BURST, release on
  // burst limit or when the owner withdraws its request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      own_q  <= '0;
      last_q <= IDX_W'(N - 1);
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid && !fifo_full) begin
            own_q <= pick_idx;
            cnt_q <= CNT_W'(1);
            if (MAX_BURST == 1) begin
              last_q <= pick_idx;
            end else begin
              state <= BURST;
            end
          end
        end
        BURST: begin
          if (!own_req) begin
            state  <= IDLE;
            last_q <= own_q;
            cnt_q  <= '0;
          end else if (!fifo_full) begin
            if (cnt_next == CNT_W'(MAX_BURST)) begin
              state  <= IDLE;
              last_q <= own_q;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int FAIR_BOUND = (N - 1) * (MB + 1) + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic           fifo_full;
  logic           fifo_wr;
  logic [W-1:0]   fifo_data;
  logic           busy;
  logic [1:0]     owner;

  int checks = 0;
  int errors = 0;

  // reference model: current owner (-1 when none), beats taken, last finished owner,
  // last picked index (what the owner output shows)
  int m_own, m_cnt, m_last, m_disp;
  int e_sel;
  logic [N-1:0] e_ack;
  logic [W-1:0] e_data;
  logic         e_wr, e_busy;
  logic [1:0]   e_owner;

  fifo_write_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(MB), .CNT_W(3), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] slice(input int i);
    return req_data[i*W +: W];
  endfunction

  task automatic model_eval();
    e_sel = -1;
    if (!reset && !fifo_full) begin
      if (m_own < 0) begin
        for (int k = N; k >= 1; k--)
          if (req[(m_last + k) % N]) e_sel = (m_last + k) % N;
      end else if (req[m_own]) begin
        e_sel = m_own;
      end
    end
    e_ack   = (e_sel >= 0) ? N'(1 << e_sel) : '0;
    e_wr    = (e_sel >= 0);
    e_data  = e_wr ? slice(e_sel) : '0;
    e_busy  = !reset && (m_own >= 0);
    e_owner = reset ? 2'd0 : 2'((m_own >= 0) ? m_own : m_disp);
  endtask

  task automatic model_commit();
    if (reset) begin
      m_own = -1; m_cnt = 0; m_last = N - 1; m_disp = 0;
    end else if (m_own < 0) begin
      if (e_sel >= 0) begin
        m_disp = e_sel;
        m_cnt  = 1;
        if (MB == 1) m_last = e_sel;
        else         m_own  = e_sel;
      end
    end else if (!req[m_own]) begin
      m_last = m_own; m_own = -1; m_cnt = 0;
    end else if (!fifo_full) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_last = m_own; m_own = -1; m_cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; fifo_full = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '1; fifo_full = 1'b0; req_data = 32'h44332211;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({ack, fifo_wr, fifo_data, busy, owner} !== 16'h0) begin
        errors++;
        $display("FAIL reset c%0d: ack=%b wr=%b data=%h busy=%b owner=%0d, want all 0",
                 c, ack, fifo_wr, fifo_data, busy, owner);
      end
      @(negedge clk);
    end
    reset = 1'b0; req = '0;
  endtask

  task automatic test_round_robin();
    int oi;
    do_reset();
    req = 4'b1111; req_data = 32'h44332211;
    for (int c = 0; c < 13; c++) begin
      #1;
      oi = (c == 0) ? 0 : (c - 1) / 4;
      checks++;
      if ({ack, fifo_wr, fifo_data, busy, owner} !==
          {4'(1 << (c / 4)), 1'b1, 8'(8'h11 * (c / 4 + 1)), (c % 4) != 0, 2'(oi)}) begin
        errors++;
        $display("FAIL rr c%0d: ack=%b wr=%b data=%h busy=%b owner=%0d, want ack=%b data=%h busy=%b owner=%0d",
                 c, ack, fifo_wr, fifo_data, busy, owner, 4'(1 << (c / 4)),
                 8'(8'h11 * (c / 4 + 1)), (c % 4) != 0, oi);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; req_data = 32'hC3B2A190;
    for (int c = 0; c < 9; c++) begin
      #1;
      checks++;
      if ({ack, fifo_wr, fifo_data, busy} !== {4'b0100, 1'b1, 8'hB2, (c % 4) != 0}) begin
        errors++;
        $display("FAIL single c%0d: ack=%b wr=%b data=%h busy=%b, want ack=0100 data=b2 busy=%b",
                 c, ack, fifo_wr, fifo_data, busy, (c % 4) != 0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full_hold();
    do_reset();
    req = 4'b1111; req_data = 32'h44332211;
    repeat (6) @(negedge clk);
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({ack, fifo_wr, busy, owner} !== {4'b0000, 1'b0, 1'b1, 2'd1}) begin
        errors++;
        $display("FAIL full_hold c%0d: ack=%b wr=%b busy=%b owner=%0d, want 0000 0 1 1",
                 c, ack, fifo_wr, busy, owner);
      end
      @(negedge clk);
    end
    fifo_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({ack, busy, owner} !== {(c < 2) ? 4'b0010 : 4'b0100, c < 2, 2'd1}) begin
        errors++;
        $display("FAIL full_resume c%0d: ack=%b busy=%b owner=%0d", c, ack, busy, owner);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_drop();
    logic [N-1:0] xa [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b1000};
    logic         xb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    req_data = 32'h44332211;
    for (int c = 0; c < 4; c++) begin
      req = (c < 2) ? 4'b1001 : 4'b1000;
      #1;
      checks++;
      if ({ack, fifo_wr, busy, owner} !== {xa[c], |xa[c], xb[c], 2'd0}) begin
        errors++;
        $display("FAIL drop c%0d: ack=%b wr=%b busy=%b owner=%0d, want ack=%b busy=%b owner=0",
                 c, ack, fifo_wr, busy, owner, xa[c], xb[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b1111; req_data = 32'h44332211;
    repeat (11) @(negedge clk);
    #1;
    checks++;
    if ({ack, busy, owner} !== {4'b0100, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL pre_reset: ack=%b busy=%b owner=%0d, want 0100 1 2", ack, busy, owner);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({ack, fifo_wr, fifo_data, busy, owner} !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset: ack=%b wr=%b data=%h busy=%b owner=%0d, want all 0",
               ack, fifo_wr, fifo_data, busy, owner);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({ack, fifo_data, busy, owner} !== {4'b0001, 8'h11, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL post_reset: ack=%b data=%h busy=%b owner=%0d, want 0001 11 0 0",
               ack, fifo_data, busy, owner);
    end
    @(negedge clk);
  endtask

  task automatic test_full_idle();
    do_reset();
    req = 4'b1010; req_data = 32'h44332211; fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({ack, fifo_wr, busy, owner} !== 8'h00) begin
        errors++;
        $display("FAIL full_idle c%0d: ack=%b wr=%b busy=%b owner=%0d, want all 0",
                 c, ack, fifo_wr, busy, owner);
      end
      @(negedge clk);
    end
    fifo_full = 1'b0;
    #1;
    checks++;
    if ({ack, fifo_data} !== {4'b0010, 8'h22}) begin
      errors++;
      $display("FAIL full_idle_release: ack=%b data=%h, want 0010 22", ack, fifo_data);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int wait_cnt [N];
    req = '0; fifo_full = 1'b0; reset = 1'b1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(1, 0) == 1) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = 8'($urandom);
        end
      fifo_full = ($urandom_range(3, 0) == 0);
      reset = (cyc == 0 || cyc == 300);
      #1;
      model_eval();
      checks++;
      if ({ack, fifo_wr, fifo_data, busy, owner} !== {e_ack, e_wr, e_data, e_busy, e_owner}) begin
        errors++;
        $display("FAIL random c%0d: got ack=%b wr=%b data=%h busy=%b owner=%0d, want ack=%b wr=%b data=%h busy=%b owner=%0d",
                 cyc, ack, fifo_wr, fifo_data, busy, owner, e_ack, e_wr, e_data, e_busy, e_owner);
      end
      for (int i = 0; i < N; i++) begin
        if (reset) wait_cnt[i] = 0;
        else if (req[i] && !fifo_full) wait_cnt[i]++;
        if (ack[i]) begin
          checks++;
          if (wait_cnt[i] > FAIR_BOUND) begin
            errors++;
            $display("FAIL fairness c%0d req%0d: waited %0d cycles, bound %0d",
                     cyc, i, wait_cnt[i], FAIR_BOUND);
          end
          wait_cnt[i] = 0;
        end
      end
      @(negedge clk);
      model_commit();
      for (int i = 0; i < N; i++) if (e_ack[i]) req[i] = 1'b0;
    end
    reset = 1'b0; req = '0; fifo_full = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    m_own = -1; m_cnt = 0; m_last = N - 1; m_disp = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_full_hold();
    test_drop();
    test_reset_mid_burst();
    test_full_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
